mw_stage_mc: RTL and testbench

MW_STAGE_MC -- requirements
Module: mw_stage_mc

---
 rtl/mw_stage_mc.sv | 236 +++++++++++++++++++++++
 tb/tb_mw_stage_mc.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mw_stage_mc.sv
// mw_stage_mc -- merged memory/writeback pipeline stage with a multi-cycle
// data-memory handshake.
//
// Captures the E-stage bundle, checks access alignment, issues one memory
// request per aligned load/store and holds it until mem_ack or a timeout.
// The pipeline is stalled through mem_busy while the request is outstanding.
// Load data is aligned and sign/zero-extended when the ack arrives.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   en, clear              stage enable / flush (bubble) from the hazard unit
//   *_e                    E-stage data and control inputs
//   *_mw                   registered stage outputs and exception flags
//   load_data_mw           aligned, extended load result (valid in DONE)
//   mem_busy               stall request, combinational
//   mem_req/addr/we/wdata  memory request, held stable while waiting
//   mem_rdata, mem_ack     memory response, valid for one cycle
module mw_stage_mc #(
  parameter int ADDR_W  = 30,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clear,
  input  logic [31:0]       alu_out_e,
  input  logic [31:0]       store_data_e,
  input  logic [4:0]        rd_e,
  input  logic [31:0]       pc_e,
  input  logic              reg_write_e,
  input  logic              mem_to_reg_e,
  input  logic              load_npc_e,
  input  logic [3:0]        mem_write_e,
  input  logic [2:0]        load_type_e,
  output logic [31:0]       alu_out_mw,
  output logic [31:0]       pc_mw,
  output logic [4:0]        rd_mw,
  output logic              reg_write_mw,
  output logic              mem_to_reg_mw,
  output logic              load_npc_mw,
  output logic [31:0]       load_data_mw,
  output logic              mem_busy,
  output logic              misalign_mw,
  output logic              bus_err_mw,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LH  = 3'd2;
  localparam logic [2:0] LT_LW  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;
  localparam logic [2:0] LT_LHU = 3'd5;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;

  logic [31:0] alu_q, sd_q, pc_q, ld_q;
  logic [4:0]  rd_q;
  logic        rw_q, m2r_q, npc_q;
  logic [3:0]  mw_q;
  logic [2:0]  lt_q;
  logic        misalign_q, bus_err_q;
  logic [7:0]  cnt_q;

  // ---------------------------------------------------------------------------
  // E-stage decode: access kind and alignment of the incoming instruction
  // ---------------------------------------------------------------------------
  logic is_load_e, is_store_e, word_e, half_e, misalign_e, access_e;

  assign is_load_e  = (load_type_e >= LT_LB) && (load_type_e <= LT_LHU);
  assign is_store_e = (mem_write_e != 4'b0000);
  assign word_e     = (load_type_e == LT_LW) || (mem_write_e == 4'b1111);
  assign half_e     = (load_type_e == LT_LH) || (load_type_e == LT_LHU) ||
                      (mem_write_e == 4'b0011);
  assign misalign_e = (word_e && (alu_out_e[1:0] != 2'b00)) ||
                      (half_e && alu_out_e[0]);
  assign access_e   = is_load_e || is_store_e;

  // A transaction in flight is never abandoned, so en/clear are ignored in WAIT.
  logic capture;
  assign capture = en && (state_q != S_WAIT);

  logic timeout_hit;
  assign timeout_hit = (state_q == S_WAIT) && !mem_ack && (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_busy = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (capture) begin
          if (!clear && access_e && !misalign_e) state_d = S_WAIT;
          else                                   state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        mem_req  = 1'b1;
        mem_busy = !mem_ack;
        if (mem_ack || timeout_hit) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load alignment and extension of the returning word
  // ---------------------------------------------------------------------------
  logic [1:0]  off;
  logic [31:0] rdata_sh;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  assign off      = alu_q[1:0];
  assign rdata_sh = mem_rdata >> {off, 3'b000};
  assign rd_byte  = rdata_sh[7:0];
  assign rd_half  = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_ext = 32'h0;
    unique case (lt_q)
      LT_LB:   load_ext = {{24{rd_byte[7]}}, rd_byte};
      LT_LH:   load_ext = {{16{rd_half[15]}}, rd_half};
      LT_LW:   load_ext = mem_rdata;
      LT_LBU:  load_ext = {24'h0, rd_byte};
      LT_LHU:  load_ext = {16'h0, rd_half};
      default: load_ext = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage registers, wait counter and response latch
  // ---------------------------------------------------------------------------
  // NOTE: every register here is plain flop state (no memory arrays), and all
  // of it is reset because the outputs are required to read zero in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_q      <= '0;
      sd_q       <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      m2r_q      <= 1'b0;
      npc_q      <= 1'b0;
      mw_q       <= '0;
      lt_q       <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      ld_q       <= '0;
      cnt_q      <= '0;
    end else if (capture) begin
      if (clear) begin
        alu_q      <= '0;
        sd_q       <= '0;
        pc_q       <= '0;
        rd_q       <= '0;
        rw_q       <= 1'b0;
        m2r_q      <= 1'b0;
        npc_q      <= 1'b0;
        mw_q       <= '0;
        lt_q       <= '0;
        misalign_q <= 1'b0;
      end else begin
        alu_q      <= alu_out_e;
        sd_q       <= store_data_e;
        pc_q       <= pc_e;
        rd_q       <= rd_e;
        rw_q       <= reg_write_e;
        m2r_q      <= mem_to_reg_e;
        npc_q      <= load_npc_e;
        mw_q       <= mem_write_e;
        lt_q       <= load_type_e;
        misalign_q <= misalign_e;
      end
      bus_err_q <= 1'b0;
      ld_q      <= '0;
      cnt_q     <= '0;
    end else if (state_q == S_WAIT) begin
      if (mem_ack) begin
        ld_q <= load_ext;
      end else if (timeout_hit) begin
        bus_err_q <= 1'b1;
        ld_q      <= '0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [7:0] we_wide;
  assign we_wide = {4'b0000, mw_q} << off;

  assign mem_addr  = mem_req ? alu_q[ADDR_W+1:2] : '0;
  assign mem_we    = mem_req ? we_wide[3:0] : 4'b0000;
  assign mem_wdata = mem_req ? (sd_q << {off, 3'b000}) : 32'h0;

  assign alu_out_mw    = alu_q;
  assign pc_mw         = pc_q;
  assign rd_mw         = rd_q;
  assign mem_to_reg_mw = m2r_q;
  assign load_npc_mw   = npc_q;
  assign misalign_mw   = misalign_q;
  assign bus_err_mw    = bus_err_q;
  // A faulting instruction must not retire a register write.
  assign reg_write_mw  = rw_q && !misalign_q && !bus_err_q;
  assign load_data_mw  = (state_q == S_DONE) ? ld_q : 32'h0;

endmodule

// File: tb/tb_mw_stage_mc.sv
// tb_mw_stage_mc -- directed bench for mw_stage_mc (TIMEOUT=4).
// Expected stage results are pushed to a scoreboard when an instruction is
// captured and popped when the stage presents that instruction's result.
module tb_mw_stage_mc;

  localparam int ADDR_W = 30;

  logic              clk = 1'b0;
  logic              rst_n, en, clear;
  logic [31:0]       alu_out_e, store_data_e, pc_e;
  logic [4:0]        rd_e;
  logic              reg_write_e, mem_to_reg_e, load_npc_e;
  logic [3:0]        mem_write_e;
  logic [2:0]        load_type_e;
  logic [31:0]       alu_out_mw, pc_mw, load_data_mw;
  logic [4:0]        rd_mw;
  logic              reg_write_mw, mem_to_reg_mw, load_npc_mw;
  logic              mem_busy, misalign_mw, bus_err_mw, mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_ack;

  always #5 clk = ~clk;

  mw_stage_mc #(.ADDR_W(ADDR_W), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .alu_out_e(alu_out_e), .store_data_e(store_data_e), .rd_e(rd_e),
    .pc_e(pc_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
    .load_npc_e(load_npc_e), .mem_write_e(mem_write_e),
    .load_type_e(load_type_e),
    .alu_out_mw(alu_out_mw), .pc_mw(pc_mw), .rd_mw(rd_mw),
    .reg_write_mw(reg_write_mw), .mem_to_reg_mw(mem_to_reg_mw),
    .load_npc_mw(load_npc_mw), .load_data_mw(load_data_mw),
    .mem_busy(mem_busy), .misalign_mw(misalign_mw), .bus_err_mw(bus_err_mw),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        bus_err;
    logic        misalign;
    logic        reg_write;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rd, input logic [31:0] pc,
                       input logic rw, input logic [3:0] mw,
                       input logic [2:0] lt);
    en           = 1'b1;
    clear        = 1'b0;
    alu_out_e    = alu;
    store_data_e = sd;
    rd_e         = rd;
    pc_e         = pc;
    reg_write_e  = rw;
    mem_to_reg_e = (lt != 3'd0);
    load_npc_e   = 1'b0;
    mem_write_e  = mw;
    load_type_e  = lt;
  endtask

  task automatic push(input string tag, input logic [31:0] data,
                      input logic be, input logic mis, input logic rw);
    exp_t e;
    e.tag = tag; e.data = data; e.bus_err = be; e.misalign = mis;
    e.reg_write = rw;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_data"},     load_data_mw, e.data);
      check({e.tag, "_bus_err"},  32'(bus_err_mw), 32'(e.bus_err));
      check({e.tag, "_misalign"}, 32'(misalign_mw), 32'(e.misalign));
      check({e.tag, "_reg_write"}, 32'(reg_write_mw), 32'(e.reg_write));
    end
  endtask

  // Hold the request for n cycles without ack, then ack with rdata.
  task automatic service(input string tag, input int n,
                         input logic [31:0] rdata);
    int busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (mem_busy === 1'b1 && mem_req === 1'b1) busy_cnt++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n));
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    #1;
    check({tag, "_busy_on_ack"}, 32'(mem_busy), 32'd0);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    check({tag, "_req_done"}, 32'(mem_req), 32'd0);
    pop_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cnt;
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    drive(32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 4'h0, 3'd0);
    en = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_req",  32'(mem_req), 32'd0);
    check("rst_busy", 32'(mem_busy), 32'd0);
    check("rst_we",   32'(mem_we), 32'd0);
    check("rst_alu",  alu_out_mw, 32'd0);
    check("rst_ld",   load_data_mw, 32'd0);
    check("rst_rw",   32'(reg_write_mw), 32'd0);
    rst_n = 1'b1;

    // Plain ALU instruction: no request, register write retires
    drive(32'h0000_1234, 32'h0, 5'd7, 32'h40, 1'b1, 4'h0, 3'd0);
    push("alu", 32'h0, 1'b0, 1'b0, 1'b1);
    tick(); en = 1'b0;
    pop_check();
    check("alu_out", alu_out_mw, 32'h0000_1234);
    check("alu_rd",  32'(rd_mw), 32'd7);
    check("alu_pc",  pc_mw, 32'h40);
    check("alu_req", 32'(mem_req), 32'd0);

    // SB at 0x102
    drive(32'h0000_0102, 32'h0000_00A5, 5'd0, 32'h44, 1'b0, 4'b0001, 3'd0);
    push("sb", 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); en = 1'b0;
    check("sb_req",   32'(mem_req), 32'd1);
    check("sb_addr",  32'(mem_addr), 32'h40);
    check("sb_we",    32'(mem_we), 32'b0100);
    check("sb_wdata", mem_wdata, 32'h00A5_0000);
    service("sb", 2, 32'h0);

    // SW at 0x300
    drive(32'h0000_0300, 32'h1234_5678, 5'd0, 32'h48, 1'b0, 4'b1111, 3'd0);
    push("sw", 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); en = 1'b0;
    check("sw_addr",  32'(mem_addr), 32'hC0);
    check("sw_we",    32'(mem_we), 32'b1111);
    check("sw_wdata", mem_wdata, 32'h1234_5678);
    service("sw", 1, 32'h0);

    // SH at 0x302
    drive(32'h0000_0302, 32'h0000_ABCD, 5'd0, 32'h4C, 1'b0, 4'b0011, 3'd0);
    push("sh", 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); en = 1'b0;
    check("sh_we",    32'(mem_we), 32'b1100);
    check("sh_wdata", mem_wdata, 32'hABCD_0000);
    service("sh", 0, 32'h0);

    // LH at 0x202, flush requested while waiting must be ignored
    drive(32'h0000_0202, 32'h0, 5'd5, 32'h50, 1'b1, 4'h0, 3'd2);
    push("lh", 32'hFFFF_8001, 1'b0, 1'b0, 1'b1);
    tick();
    en = 1'b1; clear = 1'b1;
    check("lh_we",   32'(mem_we), 32'd0);
    check("lh_addr", 32'(mem_addr), 32'h80);
    service("lh", 3, 32'h8001_1234);
    check("lh_alu_kept", alu_out_mw, 32'h0000_0202);
    check("lh_rd_kept",  32'(rd_mw), 32'd5);
    en = 1'b0; clear = 1'b0;
    alu_out_e = 32'hFFFF_FFFF;
    tick();
    check("lh_hold_data", load_data_mw, 32'hFFFF_8001);
    check("lh_hold_alu",  alu_out_mw, 32'h0000_0202);

    // LHU at 0x202
    drive(32'h0000_0202, 32'h0, 5'd6, 32'h54, 1'b1, 4'h0, 3'd5);
    push("lhu", 32'h0000_8001, 1'b0, 1'b0, 1'b1);
    tick(); en = 1'b0;
    service("lhu", 3, 32'h8001_5678);

    // LB at 0x103, LBU at 0x101, LW at 0x200
    drive(32'h0000_0103, 32'h0, 5'd8, 32'h58, 1'b1, 4'h0, 3'd1);
    push("lb", 32'hFFFF_FF80, 1'b0, 1'b0, 1'b1);
    tick(); en = 1'b0;
    service("lb", 1, 32'h8011_2233);

    drive(32'h0000_0101, 32'h0, 5'd9, 32'h5C, 1'b1, 4'h0, 3'd4);
    push("lbu", 32'h0000_00F7, 1'b0, 1'b0, 1'b1);
    tick(); en = 1'b0;
    service("lbu", 2, 32'h1122_F733);

    drive(32'h0000_0200, 32'h0, 5'd10, 32'h60, 1'b1, 4'h0, 3'd3);
    push("lw", 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    tick(); en = 1'b0;
    service("lw", 1, 32'hDEAD_BEEF);

    // Misaligned LW at 0x101: no request at all
    drive(32'h0000_0101, 32'h0, 5'd11, 32'h64, 1'b1, 4'h0, 3'd3);
    push("lw_mis", 32'h0, 1'b0, 1'b1, 1'b0);
    tick(); en = 1'b0;
    pop_check();
    req_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req !== 1'b0 || mem_busy !== 1'b0) req_cnt++;
      tick();
    end
    check("lw_mis_no_req", 32'(req_cnt), 32'd0);

    // Timeout: load without ack
    drive(32'h0000_0400, 32'h0, 5'd12, 32'h68, 1'b1, 4'h0, 3'd3);
    push("tmo", 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); en = 1'b0;
    req_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req === 1'b1) req_cnt++;
      tick();
    end
    check("tmo_req_cycles", 32'(req_cnt), 32'd4);
    check("tmo_busy", 32'(mem_busy), 32'd0);
    pop_check();

    // Reset during WAIT; a late ack is ignored
    drive(32'h0000_0500, 32'h0, 5'd13, 32'h6C, 1'b1, 4'h0, 3'd3);
    tick(); en = 1'b0;
    tick();
    check("rwait_req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    tick();
    check("rwait_req",  32'(mem_req), 32'd0);
    check("rwait_busy", 32'(mem_busy), 32'd0);
    check("rwait_alu",  alu_out_mw, 32'd0);
    check("rwait_rd",   32'(rd_mw), 32'd0);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("rwait_late_busy", 32'(mem_busy), 32'd0);
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    check("rwait_late_ld",  load_data_mw, 32'd0);
    check("rwait_late_req", 32'(mem_req), 32'd0);
    check("rwait_late_rw",  32'(reg_write_mw), 32'd0);

    // Load some state, then flush capture loads a bubble
    drive(32'h0000_0777, 32'h0, 5'd14, 32'h70, 1'b1, 4'h0, 3'd0);
    tick();
    drive(32'h0000_0600, 32'h0, 5'd15, 32'h74, 1'b1, 4'h0, 3'd3);
    clear = 1'b1;
    tick(); en = 1'b0; clear = 1'b0;
    check("clr_alu",  alu_out_mw, 32'd0);
    check("clr_pc",   pc_mw, 32'd0);
    check("clr_rd",   32'(rd_mw), 32'd0);
    check("clr_rw",   32'(reg_write_mw), 32'd0);
    check("clr_m2r",  32'(mem_to_reg_mw), 32'd0);
    check("clr_req",  32'(mem_req), 32'd0);

    // Ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    check("idle_ack_busy", 32'(mem_busy), 32'd0);
    tick();
    mem_ack = 1'b0;
    check("idle_ack_ld", load_data_mw, 32'd0);
    tick();
    check("idle_ack_req", 32'(mem_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
